// File: rtl/multicycle_ctrl.sv
// Multicycle core control FSM. It sequences fetch, decode, execute, the
// data-memory access, writeback, traps and halt. It generates the memory
// requests, the register-load enables and PC select, and counts retired
// instructions.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT    = 16,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        jump,
  input  logic        is_ecall,
  input  logic        is_ebreak,
  input  logic        csr_write,
  input  logic        illegal,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        trap_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_en,
  output logic        pc_en,
  output logic        rf_we,
  output logic        csr_we,
  output logic [1:0]  pc_sel,
  output logic        trap_valid,
  output logic [3:0]  trap_cause,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT
  } state_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_LD_FLT  = 4'd5;
  localparam logic [3:0] CAUSE_ST_FLT  = 4'd7;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam logic [5:0] TIMEOUT = 6'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [4:0]  wait_cnt, wait_cnt_nxt;
  logic        jump_q, jump_nxt;
  logic [3:0]  cause_q, cause_nxt;
  logic        mem_expire;

  // The MEM access times out when this cycle's increment would reach the limit.
  assign mem_expire = (({1'b0, wait_cnt} + 6'd1) == TIMEOUT);

  // State, wait counter, jump flag, trap cause and retired-instruction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      wait_cnt <= '0;
      jump_q   <= 1'b0;
      cause_q  <= '0;
      instret  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      jump_q   <= jump_nxt;
      cause_q  <= cause_nxt;
      if (pc_en && (state != TRAP))
        instret <= instret + 32'd1;
    end
  end

  // Next-state and output decode. rst_n gates every output, so requests and
  // write enables drop as soon as reset is asserted, even in the middle of
  // an access or a trap.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    jump_nxt     = jump_q;
    cause_nxt    = cause_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    rf_we        = 1'b0;
    csr_we       = 1'b0;
    pc_sel       = PC_SEQ;
    trap_valid   = 1'b0;
    trap_cause   = '0;
    halted       = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_en     = 1'b1;
            state_nxt = DECODE;
          end
        end
        DECODE: begin
          if (illegal) begin
            cause_nxt = CAUSE_ILLEGAL;
            state_nxt = TRAP;
          end else if (is_ecall) begin
            cause_nxt = CAUSE_ECALL;
            state_nxt = TRAP;
          end else if (is_ebreak) begin
            if (HALT_ON_EBREAK) begin
              state_nxt = HALT;
            end else begin
              cause_nxt = CAUSE_EBREAK;
              state_nxt = TRAP;
            end
          end else begin
            state_nxt = EXEC;
          end
        end
        EXEC: begin
          jump_nxt = 1'b0;
          if (mem_read || mem_write) begin
            wait_cnt_nxt = '0;
            state_nxt    = MEM;
          end else if (branch) begin
            pc_en     = 1'b1;
            pc_sel    = branch_taken ? PC_TARGET : PC_SEQ;
            state_nxt = FETCH;
          end else begin
            jump_nxt  = jump;
            state_nxt = WB;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = mem_write;
          if (dmem_ready) begin
            if (mem_write) begin
              pc_en     = 1'b1;
              state_nxt = FETCH;
            end else begin
              state_nxt = WB;
            end
          end else begin
            wait_cnt_nxt = wait_cnt + 5'd1;
            if (mem_expire) begin
              cause_nxt = mem_write ? CAUSE_ST_FLT : CAUSE_LD_FLT;
              state_nxt = TRAP;
            end
          end
        end
        WB: begin
          rf_we     = reg_write;
          csr_we    = csr_write;
          pc_en     = 1'b1;
          pc_sel    = jump_q ? PC_TARGET : PC_SEQ;
          jump_nxt  = 1'b0;
          state_nxt = FETCH;
        end
        TRAP: begin
          trap_valid = 1'b1;
          trap_cause = cause_q;
          if (trap_ack) begin
            pc_en     = 1'b1;
            pc_sel    = PC_TRAP;
            state_nxt = FETCH;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. For each instruction it builds the full
// expected per-cycle trace from the phase rules: fetch, decode, exec, mem,
// writeback, trap and halt. A driver replays that trace into the DUT, and a
// compare process checks every cycle against it.
module tb_multicycle_ctrl;
  localparam int TO      = 16;
  localparam bit HALT_EB = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_write = 0, mem_read = 0, mem_write = 0, branch = 0, jump = 0;
  logic is_ecall = 0, is_ebreak = 0, csr_write = 0, illegal = 0;
  logic branch_taken = 0, imem_ready = 0, dmem_ready = 0, trap_ack = 0;
  logic imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we, csr_we;
  logic [1:0] pc_sel;
  logic trap_valid;
  logic [3:0] trap_cause;
  logic halted;
  logic [31:0] instret;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .HALT_ON_EBREAK(HALT_EB)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .is_ecall(is_ecall), .is_ebreak(is_ebreak),
    .csr_write(csr_write), .illegal(illegal), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .trap_ack(trap_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_en(ir_en), .pc_en(pc_en), .rf_we(rf_we), .csr_we(csr_we),
    .pc_sel(pc_sel), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we, csr_we;
    logic [1:0] pc_sel;
    logic trap_valid;
    logic [3:0] trap_cause;
    logic halted;
  } outs_t;

  // ph: 0 = other, 1 = fetch (rdy drives imem_ready), 2 = mem (rdy drives dmem_ready)
  typedef struct {
    int   ph;
    logic rdy;
    logic ack;
    logic retire;
    outs_t o;
  } cyc_t;

  typedef struct {
    logic rw, mr, mw, br, jp, ec, eb, cw, il, tk;
    int   fw, mwait, ackw;
  } ins_t;

  cyc_t        q[$];
  outs_t       exp_o;
  logic [31:0] exp_ir;
  logic [31:0] m_instret = 0;
  logic        chk_en = 0;
  logic        noise = 0;
  int          req_cnt = 0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic ins_t mk(input string flags, input logic tk, input int fw,
                              input int mwait, input int ackw);
    ins_t d;
    d = '{default: 0};
    d.tk = tk; d.fw = fw; d.mwait = mwait; d.ackw = ackw;
    for (int unsigned i = 0; i < flags.len(); i++) begin
      case (flags[i])
        "r": d.rw = 1; "l": d.mr = 1; "s": d.mw = 1; "b": d.br = 1;
        "j": d.jp = 1; "e": d.ec = 1; "k": d.eb = 1; "c": d.cw = 1;
        "i": d.il = 1;
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic void push(input int ph, input logic rdy, input logic ack,
                               input logic retire, input outs_t o);
    cyc_t c;
    c.ph = ph; c.rdy = rdy; c.ack = ack; c.retire = retire; c.o = o;
    q.push_back(c);
  endfunction

  function automatic void gen_trap(input logic [3:0] cause, input int ackw);
    outs_t o;
    for (int i = 0; i <= ackw; i++) begin
      o = '0;
      o.trap_valid = 1; o.trap_cause = cause;
      if (i == ackw) begin o.pc_en = 1; o.pc_sel = 2'b10; end
      push(0, 0, (i == ackw), 0, o);
    end
  endfunction

  // Expected trace of one instruction, from FETCH until control returns to FETCH.
  function automatic void gen(input ins_t d, input int halt_cycles);
    outs_t o;
    for (int i = 0; i <= d.fw; i++) begin
      o = '0; o.imem_req = 1; o.ir_en = (i == d.fw);
      push(1, (i == d.fw), 0, 0, o);
    end
    push(0, 0, 0, 0, '0);                          // decode
    if (d.il)      begin gen_trap(4'd2, d.ackw);  return; end
    if (d.ec)      begin gen_trap(4'd11, d.ackw); return; end
    if (d.eb) begin
      if (HALT_EB) begin
        for (int i = 0; i < halt_cycles; i++) begin
          o = '0; o.halted = 1; push(0, 0, 0, 0, o);
        end
      end else begin
        gen_trap(4'd3, d.ackw);
      end
      return;
    end
    if (d.br && !d.mr && !d.mw) begin
      o = '0; o.pc_en = 1; o.pc_sel = d.tk ? 2'b01 : 2'b00;
      push(0, 0, 0, 1, o);
      return;
    end
    push(0, 0, 0, 0, '0);                          // exec
    if (d.mr || d.mw) begin
      if (d.mwait >= 1 && d.mwait <= TO) begin
        for (int i = 1; i <= d.mwait; i++) begin
          o = '0; o.dmem_req = 1; o.dmem_we = d.mw;
          if (i == d.mwait && d.mw) o.pc_en = 1;
          push(2, (i == d.mwait), 0, (i == d.mwait && d.mw), o);
        end
        if (d.mw) return;
      end else begin
        for (int i = 1; i <= TO; i++) begin
          o = '0; o.dmem_req = 1; o.dmem_we = d.mw;
          push(2, 0, 0, 0, o);
        end
        gen_trap(d.mw ? 4'd7 : 4'd5, d.ackw);
        return;
      end
    end
    o = '0; o.rf_we = d.rw; o.csr_we = d.cw; o.pc_en = 1;
    o.pc_sel = d.jp ? 2'b01 : 2'b00;
    push(0, 0, 0, 1, o);
  endfunction

  task automatic run(input ins_t d, input int halt_cycles, input int stop_at);
    q.delete();
    gen(d, halt_cycles);
    req_cnt = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (stop_at >= 0 && i >= stop_at) break;
      @(posedge clk); #1;
      if (i == 0) begin
        reg_write = d.rw; mem_read = d.mr; mem_write = d.mw; branch = d.br;
        jump = d.jp; is_ecall = d.ec; is_ebreak = d.eb; csr_write = d.cw;
        illegal = d.il; branch_taken = d.tk;
      end
      imem_ready = (q[i].ph == 1) ? q[i].rdy : noise;
      dmem_ready = (q[i].ph == 2) ? q[i].rdy : noise;
      trap_ack   = q[i].ack;
      exp_o  = q[i].o;
      exp_ir = m_instret;
      chk_en = 1;
      @(negedge clk); #1;
      if (q[i].retire) m_instret = m_instret + 1;
    end
    chk_en = 0;
  endtask

  // Park in FETCH for one cycle and pin the retired count to a literal.
  task automatic idle_check(input string nm, input logic [31:0] exp_cnt);
    @(posedge clk); #1;
    imem_ready = 0; dmem_ready = 0; trap_ack = 0;
    #1;
    chk({nm, "_instret"}, instret, exp_cnt);
    chk({nm, "_imem_req"}, 32'(imem_req), 1);
  endtask

  task automatic reset_now(input string nm);
    rst_n = 0; #1;
    chk({nm, "_rst_imem_req"}, 32'(imem_req), 0);
    chk({nm, "_rst_dmem_req"}, 32'(dmem_req), 0);
    chk({nm, "_rst_dmem_we"}, 32'(dmem_we), 0);
    chk({nm, "_rst_rf_we"}, 32'(rf_we), 0);
    chk({nm, "_rst_trap_valid"}, 32'(trap_valid), 0);
    chk({nm, "_rst_trap_cause"}, 32'(trap_cause), 0);
    chk({nm, "_rst_halted"}, 32'(halted), 0);
    chk({nm, "_rst_instret"}, instret, 0);
    imem_ready = 0; dmem_ready = 0; trap_ack = 0;
    reg_write = 0; mem_read = 0; mem_write = 0; branch = 0; jump = 0;
    is_ecall = 0; is_ebreak = 0; csr_write = 0; illegal = 0; branch_taken = 0;
    @(negedge clk); #1;
    rst_n = 1;
    m_instret = 0;
  endtask

  // Advance one more cycle inside the interrupted phase, confirm the DUT is
  // there, then assert reset mid-cycle.
  task automatic mid_reset(input string nm, input logic in_mem);
    @(posedge clk); #1;
    imem_ready = 0; dmem_ready = 0; trap_ack = 0;
    #1;
    if (in_mem) chk({nm, "_pre_dmem_req"}, 32'(dmem_req), 1);
    else        chk({nm, "_pre_trap_valid"}, 32'(trap_valid), 1);
    reset_now(nm);
  endtask

  // Per-cycle comparison against the expected trace.
  always @(negedge clk) begin
    if (chk_en) begin
      outs_t a;
      a.imem_req = imem_req; a.dmem_req = dmem_req; a.dmem_we = dmem_we;
      a.ir_en = ir_en; a.pc_en = pc_en; a.rf_we = rf_we; a.csr_we = csr_we;
      a.pc_sel = pc_sel; a.trap_valid = trap_valid; a.trap_cause = trap_cause;
      a.halted = halted;
      chk("outs", 32'(a), 32'(exp_o));
      chk("instret", instret, exp_ir);
      if (dmem_req) req_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    reset_now("por");
    run(mk("r", 0, 1, 0, 0), 0, -1);            // ADD, ready on 2nd fetch cycle
    idle_check("add", 1);
    run(mk("rl", 0, 0, 3, 0), 0, -1);           // load, ready on 3rd MEM cycle
    chk("load_req_cycles", req_cnt, 3);
    idle_check("load", 2);
    run(mk("s", 0, 0, 0, 2), 0, -1);            // store, never ready -> cause 7
    chk("store_to_req_cycles", req_cnt, 16);
    idle_check("store_to", 2);
    run(mk("b", 1, 0, 0, 0), 0, -1);            // taken branch
    idle_check("br_taken", 3);
    run(mk("b", 0, 2, 0, 0), 0, -1);            // not-taken branch
    idle_check("br_not", 4);
    run(mk("rj", 0, 0, 0, 0), 0, -1);           // jal
    idle_check("jal", 5);
    noise = 1;
    run(mk("rc", 0, 1, 0, 0), 0, -1);           // csr write, stray ready strobes
    run(mk("rl", 0, 0, 16, 0), 0, -1);          // ready exactly at timeout -> completes
    chk("load_edge_req_cycles", req_cnt, 16);
    run(mk("s", 0, 0, 16, 0), 0, -1);           // store ready at timeout
    run(mk("s", 0, 1, 2, 0), 0, -1);
    noise = 0;
    idle_check("noise", 9);
    run(mk("rl", 0, 0, 0, 0), 0, -1);           // load timeout -> cause 5
    run(mk("e", 0, 0, 0, 1), 0, -1);            // ecall -> cause 11
    run(mk("ie", 0, 0, 0, 0), 0, -1);           // illegal beats ecall -> cause 2
    run(mk("ke", 0, 0, 0, 3), 0, -1);           // ecall beats ebreak
    idle_check("traps", 9);
    run(mk("s", 0, 0, 0, 0), 0, 5);             // store stopped after 2 MEM cycles
    mid_reset("mid_mem", 1);
    run(mk("r", 0, 0, 0, 0), 0, -1);
    idle_check("after_mem_rst", 1);
    run(mk("e", 0, 0, 0, 5), 0, 4);             // ecall stopped after 2 TRAP cycles
    mid_reset("mid_trap", 0);
    run(mk("r", 0, 0, 0, 0), 0, -1);
    noise = 1;
    run(mk("k", 0, 0, 0, 0), 100, -1);          // ebreak -> halt for 100 cycles
    noise = 0;
    chk("halt_held", 32'(halted), 1);
    chk("halt_instret", instret, 1);
    reset_now("halt");
    run(mk("r", 0, 0, 0, 0), 0, -1);
    idle_check("post_halt", 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max cycles a MEM access waits for dmem_ready before faulting.
REQ-002 Parameter HALT_ON_EBREAK, default 1: 1 = ebreak enters HALT; 0 = ebreak traps.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 reg_write, mem_read, mem_write, branch, jump, is_ecall, is_ebreak, csr_write  in  1 each  main-decoder outputs for the instruction held in IR.
REQ-006 illegal  in  1  decoder found an unrecognised opcode.
REQ-007 branch_taken  in  1  ALU branch compare result, valid in EXEC.
REQ-008 imem_ready, dmem_ready  in  1 each  memory completion strobes.
REQ-009 trap_ack  in  1  trap handler accepted the trap.
REQ-010 imem_req, dmem_req, dmem_we  out  1 each  memory request; dmem_we = store.
REQ-011 ir_en, pc_en, rf_we, csr_we  out  1 each  register-load enables.
REQ-012 pc_sel  out  2  00 PC+4, 01 branch/jump target, 10 trap vector.
REQ-013 trap_valid  out  1; trap_cause  out  4  pending trap and cause.
REQ-014 halted  out  1  core halted.
REQ-015 instret  out  32  retired-instruction count.

Function
REQ-016 States: FETCH, DECODE, EXEC, MEM, WB, TRAP, HALT; all outputs are decoded from state and inputs and are 0 unless stated.
REQ-017 FETCH: imem_req=1 until imem_ready; on imem_ready, ir_en=1 for that cycle and next state is DECODE.
REQ-018 DECODE: one cycle; priority illegal (cause 2) > is_ecall (cause 11) > is_ebreak (cause 3) -> TRAP, except ebreak with HALT_ON_EBREAK=1 -> HALT; otherwise -> EXEC.
REQ-019 EXEC: one cycle; mem_read or mem_write -> MEM; branch -> FETCH with pc_en=1 and pc_sel=01 if branch_taken, else 00; jump -> WB with jump flag latched; all others -> WB.
REQ-020 MEM: dmem_req=1 and dmem_we=mem_write until dmem_ready; on dmem_ready, a load goes to WB and a store goes to FETCH with pc_en=1 and pc_sel=00.
REQ-021 A 5-bit wait counter clears on entry to MEM and increments each MEM cycle without dmem_ready; when it reaches MEM_TIMEOUT, the access aborts to TRAP with cause 5 (load) or 7 (store).
REQ-022 dmem_ready in the same cycle the counter reaches MEM_TIMEOUT completes the access normally; ready has priority over timeout.
REQ-023 WB: one cycle; rf_we=reg_write, csr_we=csr_write, pc_en=1, pc_sel=01 if the latched jump flag is set else 00; next state is FETCH.
REQ-024 TRAP: trap_valid=1 and trap_cause held stable until trap_ack; on trap_ack, pc_en=1, pc_sel=10, and next state is FETCH.
REQ-025 HALT: absorbing state with halted=1; only rst_n leaves it.
REQ-026 instret increments by 1 on each pc_en cycle outside TRAP and wraps from 0xFFFFFFFF to 0.
REQ-027 rf_we, csr_we and dmem_we are never asserted in TRAP or HALT, and no register write occurs for a trapped instruction.
REQ-028 imem_ready outside FETCH and dmem_ready outside MEM are ignored.

Reset
REQ-029 rst_n low asynchronously forces state FETCH, instret=0, wait counter=0, jump flag=0, trap_cause=0, and all enables, requests, trap_valid and halted to 0.
REQ-030 On the first rising clk edge after rst_n rises, imem_req=1.
REQ-031 Reset asserted mid-MEM or mid-TRAP drops dmem_req or trap_valid immediately, with no partial write.

Verification
REQ-032 ADD (reg_write=1), imem_ready on the 2nd FETCH cycle -> FETCH x2, DECODE, EXEC, WB with rf_we=1 and pc_en=1; instret=1.
REQ-033 Load, dmem_ready after 3 MEM cycles -> dmem_req high 3 cycles, dmem_we=0, then WB with rf_we=1.
REQ-034 Store, dmem_ready never asserted, MEM_TIMEOUT=16 -> dmem_req high 16 cycles, then trap_valid=1 and trap_cause=7 with no rf_we; trap_ack -> pc_sel=10 and instret unchanged.
REQ-035 Taken branch -> EXEC asserts pc_en=1 and pc_sel=01 with no WB; not-taken branch -> pc_sel=00.
REQ-036 ecall -> trap_cause=11; ebreak with HALT_ON_EBREAK=1 -> halted=1 held for 100 cycles with imem_req=0; illegal together with is_ecall -> cause 2.
REQ-037 rst_n pulsed low mid-MEM -> dmem_req=0 in the same cycle, and FETCH with instret=0 after release.
